instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle MIPS datapath (`TOP_level`). It owns the program counter and issues word reads to an instruction memory over a req/ready handshake. It holds each fetched instruction with `instr_valid` until the datapath accepts it, and applies branch/jump redirects and asynchronous-to-program flushes. It replaces free-running PC increment, so instruction memory may take any number of cycles to respond.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.
- `CNT_W`, 32, width of the retired-fetch counter.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address; equals `pc` while `imem_req`=1.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle; only meaningful while `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr`/`pc` hold a fetched instruction.
- `instr`  out  32  fetched instruction.
- `pc`  out  32  address of the current or outstanding instruction.
- `pc_plus4`  out  32  `pc`+4, modulo 2^32.
- `stall`  in  1  datapath cannot accept `instr` this cycle.
- `redirect`  in  1  the current instruction is a taken branch, jump, or `jr`; sampled only on acceptance.
- `redirect_pc`  in  32  target; bits [1:0] are forced to 0.
- `flush`  in  1  discard everything and restart at `flush_pc`; accepted in any state.
- `flush_pc`  in  32  restart address; bits [1:0] are forced to 0.
- `fetch_count`  out  `CNT_W`  number of accepted instructions; wraps.

## Operation
- States: FETCH, HOLD, DRAIN.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_ready`. On `imem_ready`: `instr`<=`imem_rdata`, go to HOLD.
- HOLD: `instr_valid`=1 and `imem_req`=0.
  - Acceptance occurs when `instr_valid`=1 and `stall`=0.
  - On acceptance: `fetch_count`++, `pc`<=(`redirect` ? `redirect_pc` : `pc_plus4`), go to FETCH.
  - `redirect` while `stall`=1 is ignored.
- DRAIN: a flush arrived while a request was outstanding. `imem_req` stays 1 with the old address until `imem_ready`. The returned data is discarded, `pc`<=latched flush target, go to FETCH.
- `flush` behaviour by state:
  - FETCH with `imem_ready`=0: latch `flush_pc`, go to DRAIN.
  - FETCH with `imem_ready`=1 in the same cycle: data discarded, `pc`<=`flush_pc`, go to FETCH.
  - HOLD: `instr_valid` drops next cycle, `pc`<=`flush_pc`, go to FETCH. No count increment, even if `stall`=0.
  - DRAIN: the newer `flush_pc` overwrites the latched target.
- Priority: reset > flush > acceptance/redirect > normal.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Reset values: state FETCH, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `fetch_count`=0, flush target=0. `imem_req`=0 during the reset cycle and 1 from the first cycle after reset deasserts.
- Reset mid-transaction abandons the outstanding request. Memory must tolerate `imem_req` dropping without `imem_ready`.

## Timing
- `imem_ready` is sampled combinationally in the same cycle as `imem_req`. Zero-wait memory (ready=1 immediately) gives `instr_valid` one cycle after the request cycle.
- Throughput: at best one instruction per 2 cycles (FETCH, HOLD).
- Accept-to-next-request: 1 cycle. The new `imem_addr` appears the cycle after acceptance.
- Flush-to-request: 1 cycle from HOLD or from FETCH-with-ready. From FETCH without ready, one cycle after the outstanding `imem_ready`.
- `instr`, `pc`, and `instr_valid` are registered and stable throughout HOLD regardless of `stall`.
- `pc_plus4` is combinational from `pc`.

## Structure
- Package `mips_fetch_pkg`:
  - `fetch_state_t` enum {FETCH, HOLD, DRAIN}.
  - `RESET_PC_DEFAULT`.
  - `PC_INC` = 4.
  - `align_word()` function, clears bits [1:0].
- One natural sub-module, `pc_reg`: 32-bit PC register with synchronous reset, load-enable, and next-value mux (pc+4 / redirect / flush). The FSM and counter live in `instr_fetch_unit`.

## Test plan
- Reset, zero-wait memory returning 0x2001_0005 then 0x2002_000A, `stall`=0 → `imem_addr` sequence 0x0, 0x4; `instr_valid` pulses alternate cycles; `fetch_count`=2 after the second acceptance.
- Memory with 3 wait cycles at 0x8 → `imem_addr` stays 0x8 and `imem_req` stays 1 for 4 cycles; `instr` updates once.
- HOLD with `stall`=1 for 5 cycles, `redirect`=1 with target 0x40 → `instr`/`pc` frozen and redirect ignored; after `stall`=0 with `redirect`=1, `redirect_pc`=0x43 → next `imem_addr`=0x40.
- `flush` with `flush_pc`=0x100 during FETCH, ready 2 cycles later, and a second `flush` with 0x200 in between → state DRAIN, returned word discarded, next `imem_addr`=0x200, `fetch_count` unchanged.
- `pc`=0xFFFF_FFFC accepted without redirect → next `imem_addr`=0x0000_0000. Reset asserted during an outstanding request → `imem_req`=0 and `pc`=`RESET_PC` in the reset cycle.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types, constants and helpers for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Source selected for the next program counter value.
  typedef enum logic [1:0] {
    PC_SEL_INC      = 2'd0,
    PC_SEL_REDIRECT = 2'd1,
    PC_SEL_FLUSH    = 2'd2
  } pc_sel_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with next-value selection (pc+4, redirect, flush).
module pc_reg
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  pc_sel_t     sel,
  input  logic [31:0] redirectPc,
  input  logic [31:0] flushPc,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4
);

  logic [31:0] pcNext;

  // Wraps naturally at 2^32.
  assign pcPlus4 = pc + PC_INC;

  // Next-PC mux; targets from outside are word-aligned here.
  always_comb begin
    pcNext = pcPlus4;
    case (sel)
      PC_SEL_INC:      pcNext = pcPlus4;
      PC_SEL_REDIRECT: pcNext = align_word(redirectPc);
      PC_SEL_FLUSH:    pcNext = align_word(flushPc);
      default:         pcNext = pcPlus4;
    endcase
  end

  // PC state, loaded only when the fetch FSM commands it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= align_word(RESET_PC);
    end else if (load) begin
      pc <= pcNext;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready
// handshake, holds each instruction until the datapath accepts it, and
// applies branch/jump redirects and flushes.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             flush,
  input  logic [31:0]      flush_pc,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t     state;
  fetch_state_t     nextState;
  logic             pcLoad;
  pc_sel_t          pcSel;
  logic             instrLoad;
  logic             cntInc;
  logic             tgtLoad;
  logic             useTgt;
  logic [31:0]      flushTgt;
  logic [31:0]      flushAddr;
  logic [31:0]      instrReg;
  logic [CNT_W-1:0] fetchCount;

  // A drain completes to the latched target unless a newer flush arrives.
  assign flushAddr = useTgt ? flushTgt : flush_pc;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) uPcReg (
    .clk       (CLK),
    .reset     (reset),
    .load      (pcLoad),
    .sel       (pcSel),
    .redirectPc(redirect_pc),
    .flushPc   (flushAddr),
    .pc        (pc),
    .pcPlus4   (pc_plus4)
  );

  // Request is gated by reset so an abandoned transaction drops immediately.
  assign imem_req    = !reset && ((state == FETCH) || (state == DRAIN));
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign instr       = instrReg;
  assign fetch_count = fetchCount;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and datapath control; flush outranks acceptance everywhere.
  always_comb begin
    nextState = state;
    pcLoad    = 1'b0;
    pcSel     = PC_SEL_INC;
    instrLoad = 1'b0;
    cntInc    = 1'b0;
    tgtLoad   = 1'b0;
    useTgt    = 1'b0;
    case (state)
      FETCH: begin
        if (flush) begin
          if (imem_ready) begin
            // Returning word is dropped; restart directly.
            pcLoad = 1'b1;
            pcSel  = PC_SEL_FLUSH;
          end else begin
            // Request still outstanding; wait for it to retire.
            tgtLoad   = 1'b1;
            nextState = DRAIN;
          end
        end else if (imem_ready) begin
          instrLoad = 1'b1;
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          pcLoad    = 1'b1;
          pcSel     = PC_SEL_FLUSH;
          nextState = FETCH;
        end else if (!stall) begin
          cntInc    = 1'b1;
          pcLoad    = 1'b1;
          pcSel     = redirect ? PC_SEL_REDIRECT : PC_SEL_INC;
          nextState = FETCH;
        end
      end
      DRAIN: begin
        if (flush) begin
          if (imem_ready) begin
            pcLoad    = 1'b1;
            pcSel     = PC_SEL_FLUSH;
            nextState = FETCH;
          end else begin
            tgtLoad = 1'b1;
          end
        end else if (imem_ready) begin
          pcLoad    = 1'b1;
          pcSel     = PC_SEL_FLUSH;
          useTgt    = 1'b1;
          nextState = FETCH;
        end
      end
      default: nextState = FETCH;
    endcase
  end

  // Instruction holding register, retired-fetch counter and flush target.
  always_ff @(posedge CLK) begin
    if (reset) begin
      instrReg   <= 32'h0;
      fetchCount <= '0;
      flushTgt   <= 32'h0;
    end else begin
      if (instrLoad) begin
        instrReg <= imem_rdata;
      end
      if (cntInc) begin
        fetchCount <= fetchCount + CNT_W'(1);
      end
      if (tgtLoad) begin
        flushTgt <= align_word(flush_pc);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_count;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (32)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .fetch_count(fetch_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    reset       = 1'b1;
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    flush       = 1'b0;
    flush_pc    = 32'h0;
    @(negedge CLK);
    @(negedge CLK);

    // Reset state
    check("rst_req",   imem_req,    0);
    check("rst_pc",    pc,          32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr,       32'h0);
    check("rst_count", fetch_count, 32'h0);

    // Zero-wait fetches at 0x0 and 0x4
    reset = 1'b0;
    #1;
    check("f0_req",  imem_req,  1);
    check("f0_addr", imem_addr, 32'h0);
    imem_ready = 1'b1; imem_rdata = 32'h2001_0005;
    cyc();
    check("f0_valid", instr_valid, 1);
    check("f0_instr", instr,       32'h2001_0005);
    check("f0_hreq",  imem_req,    0);
    check("f0_pc4",   pc_plus4,    32'h4);
    imem_ready = 1'b0;
    cyc();
    check("f1_valid", instr_valid, 0);
    check("f1_addr",  imem_addr,   32'h4);
    check("f1_count", fetch_count, 32'd1);
    imem_ready = 1'b1; imem_rdata = 32'h2002_000A;
    cyc();
    check("f1_valid", instr_valid, 1);
    check("f1_instr", instr,       32'h2002_000A);
    imem_ready = 1'b0;
    cyc();
    check("f2_count", fetch_count, 32'd2);
    check("f2_addr",  imem_addr,   32'h8);

    // Three wait cycles at 0x8
    for (int i = 0; i < 3; i++) begin
      check("wait_req",   imem_req,  1);
      check("wait_addr",  imem_addr, 32'h8);
      check("wait_instr", instr,     32'h2002_000A);
      cyc();
    end
    imem_ready = 1'b1; imem_rdata = 32'h8C22_0000;
    #1;
    check("wait_req4",  imem_req,  1);
    check("wait_addr4", imem_addr, 32'h8);
    cyc();
    check("wait_instr", instr, 32'h8C22_0000);

    // Stalled HOLD ignores redirect
    imem_ready = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr,       32'h8C22_0000);
      check("stall_pc",    pc,          32'h8);
      check("stall_count", fetch_count, 32'd2);
    end
    stall = 1'b0; redirect_pc = 32'h43;
    cyc();
    redirect = 1'b0;
    check("redir_addr",  imem_addr,   32'h40);
    check("redir_count", fetch_count, 32'd3);

    // Flush while a request is outstanding, then a newer flush in DRAIN
    flush = 1'b1; flush_pc = 32'h100;
    cyc();
    check("drain_req",  imem_req,  1);
    check("drain_addr", imem_addr, 32'h40);
    flush_pc = 32'h200;
    cyc();
    flush = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("drain_addr2", imem_addr, 32'h40);
    cyc();
    imem_ready = 1'b0;
    check("drain_next",  imem_addr,   32'h200);
    check("drain_valid", instr_valid, 0);
    check("drain_instr", instr,       32'h8C22_0000);
    check("drain_count", fetch_count, 32'd3);

    // Flush in HOLD with stall low: no count increment
    imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
    cyc();
    check("hflush_valid0", instr_valid, 1);
    imem_ready = 1'b0; flush = 1'b1; flush_pc = 32'h303;
    cyc();
    flush = 1'b0;
    check("hflush_addr",  imem_addr,   32'h300);
    check("hflush_valid", instr_valid, 0);
    check("hflush_count", fetch_count, 32'd3);

    // Flush coinciding with ready in FETCH
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC; imem_ready = 1'b1; imem_rdata = 32'h2222_2222;
    cyc();
    flush = 1'b0; imem_ready = 1'b0;
    check("fflush_valid", instr_valid, 0);
    check("fflush_addr",  imem_addr,   32'hFFFF_FFFC);
    check("fflush_instr", instr,       32'h1111_1111);

    // PC wrap at top of address space
    imem_ready = 1'b1; imem_rdata = 32'h3333_3333;
    cyc();
    imem_ready = 1'b0;
    check("wrap_pc",  pc,       32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    cyc();
    check("wrap_addr",  imem_addr,   32'h0);
    check("wrap_count", fetch_count, 32'd4);
    imem_ready = 1'b1; imem_rdata = 32'h4444_4444;
    cyc();
    imem_ready = 1'b0;
    cyc();
    check("pre_rst_addr", imem_addr, 32'h4);

    // Reset during an outstanding request
    reset = 1'b1;
    #1;
    check("mid_rst_req0", imem_req, 0);
    cyc();
    check("mid_rst_req",   imem_req,    0);
    check("mid_rst_pc",    pc,          32'h0);
    check("mid_rst_count", fetch_count, 32'h0);
    check("mid_rst_instr", instr,       32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_req",  imem_req,  1);
    check("post_rst_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
